// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b types for the pipeline front end: machine word,
//               NOP encoding, fetch-queue entry and fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // All-zero word decodes as a branch with no condition bits set, i.e. a NOP.
    localparam lc3b_word LC3B_NOP = 16'h0000;

    // One buffered instruction together with the address of its successor.
    typedef struct packed {
        lc3b_word ir;
        lc3b_word pc_plus2;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : DEPTH-entry circular FIFO of fetched instructions.
//               Ports: clk, reset_n (async, active-low); push/push_data write
//               the tail; pop advances the head; flush empties the queue
//               synchronously and wins over push/pop; head is the oldest
//               entry (undefined when empty); count is 0..DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  fetch_entry_t                   push_data,
    input  logic                           pop,
    input  logic                           flush,
    output fetch_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH) + 1;
    localparam int PW1 = PW + 1;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers run modulo 2*DEPTH so that full and empty are distinguishable
    // even when DEPTH is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(2 * DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    function automatic logic [IW-1:0] ptr_idx(input logic [PW-1:0] p);
        logic [PW-1:0] v;
        v = (p >= PW'(DEPTH)) ? (p - PW'(DEPTH)) : p;
        return IW'(v);
    endfunction

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    w_diff;
    logic           w_full;
    logic           w_empty;
    logic           w_do_push;
    logic           w_do_pop;

    always_comb begin
        if (r_wr_ptr >= r_rd_ptr) begin
            w_diff = {1'b0, r_wr_ptr} - {1'b0, r_rd_ptr};
        end else begin
            w_diff = {1'b0, r_wr_ptr} + PW1'(2 * DEPTH) - {1'b0, r_rd_ptr};
        end
    end

    assign count     = CW'(w_diff);
    assign w_full    = (w_diff == PW1'(DEPTH));
    assign w_empty   = (w_diff == '0);
    assign w_do_push = push & ~w_full & ~flush;
    assign w_do_pop  = pop & ~w_empty & ~flush;
    assign head      = r_mem[ptr_idx(r_rd_ptr)];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Storage carries no reset; entries are only observable once pushed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[ptr_idx(r_wr_ptr)] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : LC-3b instruction fetch. Owns the PC, issues reads on imem
//               port A, buffers returned words in fetch_queue and presents
//               the head instruction to decode.
//               Ports: clk, reset_n (async, active-low); load_pc pops the
//               head; redirect/redirect_pc flush and refetch; imem_read,
//               imem_address, imem_resp, imem_rdata form the memory port;
//               ir_out/pc_out/ir_valid present the head instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000,
    parameter int       DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir_out,
    output logic [15:0] pc_out,
    output logic        ir_valid
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t   r_state;
    fetch_state_t   w_state_next;
    lc3b_word       r_req_pc;
    lc3b_word       w_req_pc_next;
    lc3b_word       r_old_pc;
    lc3b_word       w_old_pc_next;
    logic           r_active;
    logic           w_push;
    logic           w_flush;
    logic           w_pop;
    logic [CW-1:0]  w_count;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_data;
    lc3b_word       w_redirect_target;
    int             w_fill_after_push;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .count     (w_count)
    );

    assign w_redirect_target = {redirect_pc[15:1], 1'b0};
    assign ir_valid          = (w_count != '0);
    // A redirect flushes the queue, so a pop on the same cycle is moot.
    assign w_pop             = load_pc & ir_valid & ~redirect;
    assign w_push_data       = '{ir: imem_rdata, pc_plus2: r_req_pc + 16'd2};

    always_comb begin
        w_fill_after_push = int'(w_count) + 1 - (w_pop ? 1 : 0);
    end

    // r_active holds imem_read low through reset and releases it on the
    // first clock edge after reset_n deasserts.
    assign imem_read    = r_active & (r_state != WAIT);
    // While squashing, the abandoned address is kept on the bus until its
    // response arrives so the memory sees a stable request.
    assign imem_address = (r_state == SQUASH) ? r_old_pc : r_req_pc;
    assign ir_out       = ir_valid ? w_head.ir       : LC3B_NOP;
    assign pc_out       = ir_valid ? w_head.pc_plus2 : 16'h0000;

    always_comb begin
        w_state_next  = r_state;
        w_req_pc_next = r_req_pc;
        w_old_pc_next = r_old_pc;
        w_push        = 1'b0;
        w_flush       = 1'b0;
        case (r_state)
            REQ: begin
                if (redirect) begin
                    w_flush       = 1'b1;
                    w_req_pc_next = w_redirect_target;
                    // With the response already here the bus is free, so the
                    // new target can be requested without a squash cycle.
                    if (r_active && !imem_resp) begin
                        w_old_pc_next = r_req_pc;
                        w_state_next  = SQUASH;
                    end
                end else if (r_active && imem_resp) begin
                    w_push        = 1'b1;
                    w_req_pc_next = r_req_pc + 16'd2;
                    if (w_fill_after_push >= DEPTH) begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    w_flush       = 1'b1;
                    w_req_pc_next = w_redirect_target;
                    w_state_next  = REQ;
                end else if (w_pop) begin
                    w_state_next = REQ;
                end
            end
            SQUASH: begin
                if (redirect) begin
                    w_req_pc_next = w_redirect_target;
                end
                if (imem_resp) begin
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= REQ;
            r_req_pc <= RESET_PC;
            r_old_pc <= RESET_PC;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_req_pc <= w_req_pc_next;
            r_old_pc <= w_old_pc_next;
            r_active <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A queue-based model of
//               the fetch rules is compared against the DUT every cycle;
//               directed phases add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          DEPTH    = 2;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        load_pc     = 1'b0;
    logic        redirect    = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp   = 1'b0;
    logic [15:0] imem_rdata  = 16'h0000;
    logic [15:0] ir_out;
    logic [15:0] pc_out;
    logic        ir_valid;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_pc      (load_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .ir_out       (ir_out),
        .pc_out       (pc_out),
        .ir_valid     (ir_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory: word at address a is 0x1000 + a/2 + 1; responds mem_lat
    // cycles after the first cycle a request is seen.
    // ------------------------------------------------------------------
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + {1'b0, a[15:1]} + 16'd1;
    endfunction

    int          mem_lat     = 0;
    int          mem_age     = 0;
    bit          mem_pending = 1'b0;
    logic [15:0] mem_addr    = 16'h0000;

    task automatic mem_drive();
        imem_resp = 1'b0;
        if (!reset_n || !imem_read) begin
            mem_pending = 1'b0;
            return;
        end
        if (!mem_pending) begin
            mem_pending = 1'b1;
            mem_age     = 0;
            mem_addr    = imem_address;
        end else begin
            mem_age++;
            chk("addr_stable", imem_address, mem_addr);
        end
        if (mem_age >= mem_lat) begin
            imem_resp   = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_pending = 1'b0;
        end
    endtask

    task automatic tick(input logic ld, input logic rd, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        mem_drive();
        load_pc     = ld;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of {ir, pc+2}, the next fetch address,
    // and flags for "stalled on a full queue" and "draining a squashed read".
    // ------------------------------------------------------------------
    logic [31:0] mq[$];
    logic [15:0] m_pc     = RESET_PC;
    logic [15:0] m_old    = RESET_PC;
    bit          m_started = 1'b0;
    bit          m_stall   = 1'b0;
    bit          m_squash  = 1'b0;

    task automatic model_step();
        logic [15:0] tgt;
        bit          do_pop;
        tgt    = redirect_pc & 16'hFFFE;
        do_pop = load_pc && (mq.size() > 0);
        if (!m_started) begin
            m_started = 1'b1;
            if (redirect) begin
                mq.delete();
                m_pc = tgt;
            end
            return;
        end
        if (redirect) begin
            if (m_squash) begin
                m_pc = tgt;
                if (imem_resp) m_squash = 1'b0;
            end else begin
                mq.delete();
                if (!m_stall && !imem_resp) begin
                    m_squash = 1'b1;
                    m_old    = m_pc;
                end
                m_stall = 1'b0;
                m_pc    = tgt;
            end
        end else if (m_squash) begin
            if (imem_resp) m_squash = 1'b0;
        end else if (m_stall) begin
            if (do_pop) begin
                void'(mq.pop_front());
                m_stall = 1'b0;
            end
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (imem_resp) begin
                mq.push_back({imem_rdata, 16'(m_pc + 16'd2)});
                m_pc = m_pc + 16'd2;
                if (mq.size() == DEPTH) m_stall = 1'b1;
            end
        end
    endtask

    initial begin : compare_proc
        logic        exp_read;
        logic [31:0] hd;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("m_rst_read",  {15'd0, imem_read}, 16'd0);
                chk("m_rst_valid", {15'd0, ir_valid},  16'd0);
                chk("m_rst_ir",    ir_out, 16'h0000);
                chk("m_rst_pc",    pc_out, 16'h0000);
                mq.delete();
                m_pc      = RESET_PC;
                m_old     = RESET_PC;
                m_started = 1'b0;
                m_stall   = 1'b0;
                m_squash  = 1'b0;
            end else begin
                exp_read = m_started && !m_stall;
                chk("m_imem_read", {15'd0, imem_read}, {15'd0, exp_read});
                if (exp_read) begin
                    chk("m_imem_address", imem_address, m_squash ? m_old : m_pc);
                end
                chk("m_ir_valid", {15'd0, ir_valid}, (mq.size() > 0) ? 16'd1 : 16'd0);
                hd = (mq.size() > 0) ? mq[0] : 32'h0;
                chk("m_ir_out", ir_out, hd[31:16]);
                chk("m_pc_out", pc_out, hd[15:0]);
                model_step();
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed phases
    // ------------------------------------------------------------------
    initial begin : stim_proc
        bit found;

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 16'h0000);
        chk("rst_imem_read", {15'd0, imem_read}, 16'd0);
        chk("rst_ir_out",    ir_out, 16'h0000);
        chk("rst_pc_out",    pc_out, 16'h0000);
        chk("rst_ir_valid",  {15'd0, ir_valid}, 16'd0);

        // Streaming with load_pc held high
        mem_lat = 0;
        reset_n = 1'b1;
        tick(1'b1, 1'b0, 16'h0000);
        chk("A_read",  {15'd0, imem_read}, 16'd1);
        chk("A_addr0", imem_address, 16'h0000);
        tick(1'b1, 1'b0, 16'h0000);
        chk("A_ir0",   ir_out, 16'h1001);
        chk("A_pc0",   pc_out, 16'h0002);
        chk("A_addr1", imem_address, 16'h0002);
        tick(1'b1, 1'b0, 16'h0000);
        chk("A_ir1",   ir_out, 16'h1002);
        chk("A_pc1",   pc_out, 16'h0004);
        chk("A_addr2", imem_address, 16'h0004);
        tick(1'b1, 1'b0, 16'h0000);
        chk("A_ir2",   ir_out, 16'h1003);
        chk("A_pc2",   pc_out, 16'h0006);

        // Fill the queue with load_pc low
        reset_n   = 1'b0;
        imem_resp = 1'b0;
        tick(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("B_full_read",  {15'd0, imem_read}, 16'd0);
        chk("B_full_valid", {15'd0, ir_valid},  16'd1);
        chk("B_full_ir",    ir_out, 16'h1001);
        repeat (3) tick(1'b0, 1'b0, 16'h0000);
        chk("B_still_wait", {15'd0, imem_read}, 16'd0);
        mem_lat = 3;
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("B_reread",      {15'd0, imem_read}, 16'd1);
        chk("B_reread_addr", imem_address, 16'h0004);
        chk("B_head_adv",    ir_out, 16'h1002);

        // Redirect while the read at 0x0004 is pending
        redirect    = 1'b1;
        redirect_pc = 16'h3000;
        tick(1'b0, 1'b0, 16'h0000);
        chk("C_hold_addr", imem_address, 16'h0004);
        chk("C_flushed",   {15'd0, ir_valid}, 16'd0);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("C_resp_addr", imem_address, 16'h0004);
        chk("C_resp_seen", {15'd0, imem_resp}, 16'd1);
        tick(1'b0, 1'b0, 16'h0000);
        chk("C_new_addr",  imem_address, 16'h3000);
        chk("C_discarded", {15'd0, ir_valid}, 16'd0);
        repeat (3) tick(1'b0, 1'b0, 16'h0000);
        chk("C_no_valid_yet", {15'd0, ir_valid}, 16'd0);
        tick(1'b0, 1'b0, 16'h0000);
        chk("C_valid", {15'd0, ir_valid}, 16'd1);
        chk("C_ir",    ir_out, 16'h2801);
        chk("C_pc",    pc_out, 16'h3002);

        // Redirect on the same cycle as a response
        mem_lat = 1;
        found   = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 1'b0, 16'h0000);
            if (imem_resp) begin
                found       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 16'h4000;
            end
        end
        chk("D_resp_found", {15'd0, found}, 16'd1);
        tick(1'b0, 1'b0, 16'h0000);
        chk("D_read",  {15'd0, imem_read}, 16'd1);
        chk("D_addr",  imem_address, 16'h4000);
        chk("D_valid", {15'd0, ir_valid}, 16'd0);

        // Wrap at 0xFFFE; bit 0 of the target is ignored
        mem_lat = 0;
        tick(1'b1, 1'b1, 16'hFFFF);
        tick(1'b1, 1'b0, 16'h0000);
        chk("E_addr_fffe", imem_address, 16'hFFFE);
        tick(1'b1, 1'b0, 16'h0000);
        chk("E_ir",      ir_out, 16'h9000);
        chk("E_pc_wrap", pc_out, 16'h0000);
        chk("E_addr0",   imem_address, 16'h0000);

        // Asynchronous reset with a full queue
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        chk("F_full_valid", {15'd0, ir_valid},  16'd1);
        chk("F_full_read",  {15'd0, imem_read}, 16'd0);
        #2;
        reset_n   = 1'b0;
        imem_resp = 1'b0;
        #1;
        chk("F_async_valid", {15'd0, ir_valid}, 16'd0);
        chk("F_async_ir",    ir_out, 16'h0000);
        chk("F_async_pc",    pc_out, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b1;
        mem_lat = 3;
        tick(1'b0, 1'b0, 16'h0000);
        chk("F_first_addr", imem_address, RESET_PC);

        // Asynchronous reset while squashing
        redirect    = 1'b1;
        redirect_pc = 16'h5000;
        tick(1'b0, 1'b0, 16'h0000);
        chk("G_squash_addr", imem_address, 16'h0000);
        chk("G_squash_read", {15'd0, imem_read}, 16'd1);
        #2;
        reset_n   = 1'b0;
        imem_resp = 1'b0;
        #1;
        chk("G_async_read",  {15'd0, imem_read}, 16'd0);
        chk("G_async_valid", {15'd0, ir_valid},  16'd0);
        tick(1'b0, 1'b0, 16'h0000);
        reset_n = 1'b1;
        chk("G_release_read", {15'd0, imem_read}, 16'd0);
        tick(1'b1, 1'b0, 16'h0000);
        chk("G_first_read", {15'd0, imem_read}, 16'd1);
        chk("G_first_addr", imem_address, RESET_PC);
        mem_lat = 0;
        repeat (6) tick(1'b1, 1'b0, 16'h0000);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
